// File: rtl/date_set_ctrl.sv
// Month/day edit controller: debounced buttons, set-month/set-day session,
// load strobes to the calendar counter, display data and blink mask.
module date_set_ctrl #(
  parameter int DEB_MS     = 20,
  parameter int BLINK_MS   = 250,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic        clk,
  input  logic        R,
  input  logic        ce1ms,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [7:0]  cur_m,
  input  logic [7:0]  cur_d,
  output logic        L,
  output logic        M_D,
  output logic [5:0]  DI,
  output logic [15:0] disp_dat,
  output logic [3:0]  blank,
  output logic        run_en
);

  localparam int DW = $clog2(DEB_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);

  typedef enum logic [2:0] {
    RUN, SET_M, SET_D, COMMIT_M, COMMIT_D
  } state_t;

  state_t state, state_nx;

  function automatic logic [4:0] dim(input logic [3:0] m);
    case (m)
      4'd2:                    dim = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_val(input logic [7:0] v);
    return {4'd0, v[7:4]} * 8'd10 + {4'd0, v[3:0]};
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  logic [1:0] raw, sync1, sync2, prs;
  logic       p_mode, p_inc, inc_ok;

  assign raw = {btn_inc, btn_mode};

  // Reset high: a button held through reset never looks released.
  always_ff @(posedge clk) begin
    if (R) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic          lvl, arm, p;
    logic [DW-1:0] cnt;

    // arm gates presses until the button is seen released
    always_ff @(posedge clk) begin
      if (R) begin
        lvl <= 1'b0;
        arm <= 1'b0;
        p   <= 1'b0;
        cnt <= '0;
      end else begin
        p <= 1'b0;
        if (ce1ms) begin
          if (!sync2[b]) arm <= 1'b1;
          if (sync2[b] == lvl) begin
            cnt <= '0;
          end else if (cnt == DW'(DEB_MS - 1)) begin
            cnt <= '0;
            lvl <= sync2[b];
            p   <= sync2[b] & arm;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end

    assign prs[b] = p;
  end

  assign p_mode = prs[0];
  assign p_inc  = prs[1];
  assign inc_ok = p_inc & ~p_mode;

  logic          in_set, timeout, phase;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] ph_cnt;

  assign in_set  = (state == SET_M) || (state == SET_D);
  assign timeout = in_set && ce1ms && !p_mode && !p_inc &&
                   (to_cnt == TW'(TIMEOUT_MS - 1));

  always_ff @(posedge clk) begin
    if (R || !in_set || p_mode || p_inc) to_cnt <= '0;
    else if (ce1ms)                      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (R || state == RUN || inc_ok) begin
      ph_cnt <= '0;
      phase  <= 1'b0;
    end else if (ce1ms) begin
      if (ph_cnt == BW'(BLINK_MS - 1)) begin
        ph_cnt <= '0;
        phase  <= ~phase;
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  logic [7:0] cm_v, cd_v;
  logic [3:0] edit_m, ent_m, inc_m;
  logic [4:0] edit_d, ent_d, ent_dim, inc_dim, cur_dim;

  always_comb begin
    cm_v  = bcd_val(cur_m);
    cd_v  = bcd_val(cur_d);
    ent_m = 4'd1;
    if (bcd_ok(cur_m) && cm_v >= 8'd1 && cm_v <= 8'd12)
      ent_m = cm_v[3:0];
    ent_dim = dim(ent_m);
    ent_d   = 5'd1;
    if (bcd_ok(cur_d) && cd_v != 8'd0)
      ent_d = (cd_v > {3'b0, ent_dim}) ? ent_dim : cd_v[4:0];
    inc_m   = (edit_m == 4'd12) ? 4'd1 : edit_m + 4'd1;
    inc_dim = dim(inc_m);
    cur_dim = dim(edit_m);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      edit_m <= 4'd1;
      edit_d <= 5'd1;
    end else if (state == RUN && p_mode) begin
      edit_m <= ent_m;
      edit_d <= ent_d;
    end else if (state == SET_M && inc_ok) begin
      edit_m <= inc_m;
      edit_d <= (edit_d > inc_dim) ? inc_dim : edit_d;
    end else if (state == SET_D && inc_ok) begin
      edit_d <= (edit_d >= cur_dim) ? 5'd1 : edit_d + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (R) state <= RUN;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:      if (p_mode) state_nx = SET_M;
      SET_M:    if (p_mode)       state_nx = SET_D;
                else if (timeout) state_nx = RUN;
      SET_D:    if (p_mode)       state_nx = COMMIT_M;
                else if (timeout) state_nx = RUN;
      COMMIT_M: state_nx = COMMIT_D;
      COMMIT_D: state_nx = RUN;
      default:  state_nx = RUN;
    endcase
  end

  logic       md_q;
  logic [5:0] di_q;

  always_ff @(posedge clk) begin
    if (R) begin
      md_q <= 1'b0;
      di_q <= '0;
    end else begin
      md_q <= M_D;
      di_q <= DI;
    end
  end

  always_comb begin
    L        = 1'b0;
    M_D      = md_q;
    DI       = di_q;
    blank    = 4'b0000;
    run_en   = 1'b0;
    disp_dat = {to_bcd({2'b0, edit_m}), to_bcd({1'b0, edit_d})};
    unique case (state)
      RUN: begin
        run_en   = 1'b1;
        disp_dat = {cur_m, cur_d};
      end
      SET_M: blank = {phase, phase, 2'b00};
      SET_D: blank = {2'b00, phase, phase};
      COMMIT_M: begin
        L   = 1'b1;
        M_D = 1'b1;
        DI  = {2'b0, edit_m};
      end
      COMMIT_D: begin
        L   = 1'b1;
        M_D = 1'b0;
        DI  = {1'b0, edit_d};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// Bench for date_set_ctrl: event-level calendar edit model checked every
// settled cycle, plus directed literal checks of key display/load values.
module tb_date_set_ctrl;

  localparam int DEB_MS     = 20;
  localparam int BLINK_MS   = 250;
  localparam int TIMEOUT_MS = 10000;

  logic        clk = 1'b0;
  logic        R, ce1ms, btn_mode, btn_inc;
  logic [7:0]  cur_m, cur_d;
  logic        L, M_D, run_en;
  logic [5:0]  DI;
  logic [15:0] disp_dat;
  logic [3:0]  blank;

  date_set_ctrl #(
    .DEB_MS(DEB_MS), .BLINK_MS(BLINK_MS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .R(R), .ce1ms(ce1ms),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_m(cur_m), .cur_d(cur_d),
    .L(L), .M_D(M_D), .DI(DI),
    .disp_dat(disp_dat), .blank(blank), .run_en(run_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick   = 0;
  int cyc    = 0;

  typedef enum {M_RUN, M_SETM, M_SETD} mstate_t;
  mstate_t ms;
  int      em, ed, ph_anchor, to_anchor;
  bit      settled;
  int      dim_tab [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  int exp_md[$], exp_di[$];
  int obs_md[$], obs_di[$], obs_cyc[$];

  function automatic int dim(input int m);
    return dim_tab[m - 1];
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                 name, got, exp, cyc);
    end
  endtask

  // ce1ms: one clk high, one clk low
  initial begin
    ce1ms = 1'b0;
    forever begin
      @(negedge clk);
      ce1ms = ~ce1ms;
      if (ce1ms) tick++;
    end
  end

  task automatic wait_until(input int t);
    while (tick < t) @(negedge clk);
  endtask

  task automatic model_reset();
    ms = M_RUN;
    em = 1;
    ed = 1;
  endtask

  task automatic model_apply(input bit pm, input bit pi, input int acc);
    int mv, dv;
    bit mok, dok;
    if (pm) begin
      if (ms == M_RUN) begin
        mok = (cur_m[7:4] < 10) && (cur_m[3:0] < 10);
        dok = (cur_d[7:4] < 10) && (cur_d[3:0] < 10);
        mv  = int'(cur_m[7:4]) * 10 + int'(cur_m[3:0]);
        dv  = int'(cur_d[7:4]) * 10 + int'(cur_d[3:0]);
        em  = (mok && mv >= 1 && mv <= 12) ? mv : 1;
        if (!dok || dv == 0) ed = 1;
        else                 ed = (dv > dim(em)) ? dim(em) : dv;
        ms = M_SETM;
        ph_anchor = acc;
        to_anchor = acc;
      end else if (ms == M_SETM) begin
        ms = M_SETD;
        to_anchor = acc;
      end else begin
        exp_md.push_back(1); exp_di.push_back(em);
        exp_md.push_back(0); exp_di.push_back(ed);
        ms = M_RUN;
      end
    end else if (pi && ms != M_RUN) begin
      if (ms == M_SETM) begin
        em = (em == 12) ? 1 : em + 1;
        if (ed > dim(em)) ed = dim(em);
      end else begin
        ed = (ed >= dim(em)) ? 1 : ed + 1;
      end
      ph_anchor = acc;
      to_anchor = acc;
    end
  endtask

  task automatic press(input bit pm, input bit pi);
    int t0;
    @(negedge clk);
    settled  = 1'b0;
    t0       = tick;
    btn_mode = pm;
    btn_inc  = pi;
    wait_until(t0 + DEB_MS + 5);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_until(t0 + 2 * DEB_MS + 12);
    model_apply(pm, pi, t0 + DEB_MS);
    settled = 1'b1;
  endtask

  task automatic glitch_inc();
    settled = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_inc = ~btn_inc;
      wait_until(tick + 1);
    end
    btn_inc = 1'b0;
    wait_until(tick + DEB_MS + 10);
    settled = 1'b1;
  endtask

  task automatic check_loads();
    int n;
    check("load_count", obs_md.size(), exp_md.size());
    n = (obs_md.size() < exp_md.size()) ? obs_md.size() : exp_md.size();
    for (int i = 0; i < n; i++) begin
      check("load_M_D", obs_md[i], exp_md[i]);
      check("load_DI", obs_di[i], exp_di[i]);
      if (i % 2 == 1)
        check("load_adjacent", obs_cyc[i] - obs_cyc[i-1], 1);
    end
    obs_md.delete(); obs_di.delete(); obs_cyc.delete();
    exp_md.delete(); exp_di.delete();
  endtask

  int         dt_to, dt_ph;
  bit         unsure;
  logic       ph;
  logic [3:0] eb;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (L) begin
      obs_md.push_back(int'(M_D));
      obs_di.push_back(int'(DI));
      obs_cyc.push_back(cyc);
    end
    if (settled) begin
      unsure = 1'b0;
      dt_to  = tick - to_anchor;
      dt_ph  = tick - ph_anchor;
      if (ms != M_RUN) begin
        if (dt_to >= TIMEOUT_MS - 3 && dt_to <= TIMEOUT_MS + 3) unsure = 1'b1;
        else if (dt_to > TIMEOUT_MS + 3) ms = M_RUN;
      end
      if (!unsure) begin
        check("run_en", run_en, ms == M_RUN);
        check("L_idle", L, 1'b0);
        check("disp_dat", disp_dat,
              (ms == M_RUN) ? {cur_m, cur_d} : {bcd(em), bcd(ed)});
        if (ms == M_RUN) begin
          check("blank_run", blank, 4'b0000);
        end else if (dt_ph % BLINK_MS >= 3 &&
                     dt_ph % BLINK_MS <= BLINK_MS - 3) begin
          ph = ((dt_ph / BLINK_MS) % 2) == 1;
          eb = (ms == M_SETM) ? {ph, ph, 2'b00} : {2'b00, ph, ph};
          check("blank_edit", blank, eb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    R        = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cur_m    = 8'h03;
    cur_d    = 8'h15;
    settled  = 1'b0;
    ph_anchor = 0;
    to_anchor = 0;
    model_reset();
    repeat (4) @(negedge clk);
    R = 1'b0;
    @(posedge clk); #2;
    check("rst_run_en", run_en, 1'b1);
    check("rst_L", L, 1'b0);
    check("rst_blank", blank, 4'b0000);
    check("rst_M_D", M_D, 1'b0);
    check("rst_DI", DI, 6'd0);
    check("rst_disp", disp_dat, 16'h0315);
    wait_until(tick + 4);
    settled = 1'b1;

    // debounce: glitch gives nothing, stable press gives one step
    press(1, 0);
    check("enter_disp", disp_dat, 16'h0315);
    check("enter_run_en", run_en, 1'b0);
    glitch_inc();
    check("glitch_disp", disp_dat, 16'h0315);
    press(0, 1);
    check("deb_inc_disp", disp_dat, 16'h0415);
    press(1, 0);
    press(1, 0);
    check("c1_md0", qget(obs_md, 0), 1);
    check("c1_di0", qget(obs_di, 0), 4);
    check("c1_md1", qget(obs_md, 1), 0);
    check("c1_di1", qget(obs_di, 1), 15);
    check_loads();
    check("c1_run_en", run_en, 1'b1);

    // full edit with day clamp and day wrap
    cur_m = 8'h01;
    cur_d = 8'h31;
    press(1, 0);
    check("fe_enter", disp_dat, 16'h0131);
    press(0, 1);
    check("fe_clamp", disp_dat, 16'h0228);
    press(1, 0);
    press(0, 1);
    check("fe_wrap", disp_dat, 16'h0201);
    press(1, 0);
    check("fe_md0", qget(obs_md, 0), 1);
    check("fe_di0", qget(obs_di, 0), 2);
    check("fe_md1", qget(obs_md, 1), 0);
    check("fe_di1", qget(obs_di, 1), 1);
    check_loads();
    check("fe_run_en", run_en, 1'b1);

    // month wrap, blink, simultaneous press, timeout
    cur_m = 8'h12;
    cur_d = 8'h31;
    press(1, 0);
    check("mw_enter", disp_dat, 16'h1231);
    wait_until(ph_anchor + BLINK_MS + 125);
    check("blink_m", blank, 4'b1100);
    press(0, 1);
    check("mw_wrap", disp_dat, 16'h0131);
    press(1, 1);
    check("sim_disp", disp_dat, 16'h0131);
    check("sim_run_en", run_en, 1'b0);
    wait_until(to_anchor + 300);
    check("blink_d", blank, 4'b0011);
    wait_until(to_anchor + TIMEOUT_MS + 20);
    check("to_run_en", run_en, 1'b1);
    check("to_disp", disp_dat, 16'h1231);
    check("to_no_L", obs_md.size(), 0);

    // invalid entry values, then reset mid-edit
    cur_m = 8'h13;
    cur_d = 8'h1A;
    press(1, 0);
    check("inv_disp", disp_dat, 16'h0101);
    press(1, 0);
    @(negedge clk);
    settled = 1'b0;
    R = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_run_en", run_en, 1'b1);
    check("rst_mid_blank", blank, 4'b0000);
    check("rst_mid_L", L, 1'b0);
    repeat (2) @(negedge clk);
    R = 1'b0;
    model_reset();
    settled = 1'b1;

    // button held through reset must be released before it counts
    @(negedge clk);
    btn_mode = 1'b1;
    wait_until(tick + 3);
    @(negedge clk);
    R = 1'b1;
    repeat (3) @(negedge clk);
    R = 1'b0;
    model_reset();
    wait_until(tick + 2 * DEB_MS);
    check("held_run_en", run_en, 1'b1);
    btn_mode = 1'b0;
    wait_until(tick + DEB_MS + 10);
    press(1, 0);
    check("repress_run_en", run_en, 1'b0);
    check("repress_disp", disp_dat, 16'h0101);

    wait_until(tick + 5);
    check_loads();
    settled = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
